// File: rtl/breakout_pkg.sv
// Shared constants and types for the breakout game pixel pipeline.
package breakout_pkg;

    localparam int H_ACT_START = 144;
    localparam int V_ACT_START = 31;
    localparam int H_ACT       = 640;
    localparam int V_ACT       = 480;

    localparam logic [7:0] COL_BALL   = 8'hFF;
    localparam logic [7:0] COL_PADDLE = 8'h1F;
    localparam logic [7:0] COL_BG     = 8'h00;

    typedef enum logic {SERVE, PLAY} game_state_t;

endpackage

// File: rtl/frame_tick.sv
// Produces a single-clock tick when the timing counters first reach the frame origin.
module frame_tick (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] hc,
    input  logic [9:0] vc,
    output logic       tick
);

    logic at_origin;
    logic at_origin_q;

    assign at_origin = (hc == 10'd0) && (vc == 10'd0);
    assign tick      = at_origin & ~at_origin_q;

    // Remember whether the previous clock was already at the origin; starting at 1
    // means a reset held at the origin never produces a spurious tick.
    always_ff @(posedge clk) begin
        if (reset) at_origin_q <= 1'b1;
        else       at_origin_q <= at_origin;
    end

endmodule

// File: rtl/ball_paddle_render.sv
// Breakout game core: per-frame ball/paddle update plus registered pixel rendering.
module ball_paddle_render
    import breakout_pkg::*;
#(
    parameter int BALL_SIZE    = 8,
    parameter int PADDLE_W     = 64,
    parameter int PADDLE_H     = 8,
    parameter int PADDLE_Y     = 456,
    parameter int BALL_STEP    = 2,
    parameter int PADDLE_STEP  = 4,
    parameter int SERVE_FRAMES = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] hc,
    input  logic [9:0] vc,
    input  logic       btn_left,
    input  logic       btn_right,
    output logic [7:0] rgb,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       miss
);

    localparam int CNT_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
    localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);

    localparam logic [9:0] BALL_X0   = 10'(H_ACT / 2 - BALL_SIZE / 2);
    localparam logic [9:0] BALL_Y0   = 10'(V_ACT / 2 - BALL_SIZE / 2);
    localparam logic [9:0] PADDLE_X0 = 10'(H_ACT / 2 - PADDLE_W / 2);
    localparam logic [9:0] BSZ       = 10'(BALL_SIZE);
    localparam logic [9:0] BSTEP     = 10'(BALL_STEP);
    localparam logic [9:0] PSTEP     = 10'(PADDLE_STEP);
    localparam logic [9:0] PW        = 10'(PADDLE_W);
    localparam logic [9:0] PTOP      = 10'(PADDLE_Y);
    localparam logic [9:0] PBOT      = 10'(PADDLE_Y + PADDLE_H);
    localparam logic [9:0] X_MAX     = 10'(H_ACT - BALL_SIZE);
    localparam logic [9:0] Y_MAX     = 10'(V_ACT - BALL_SIZE);
    localparam logic [9:0] Y_HIT     = 10'(PADDLE_Y - BALL_SIZE);
    localparam logic [9:0] P_MAX     = 10'(H_ACT - PADDLE_W);
    localparam logic [9:0] P_RCLAMP  = 10'(H_ACT - PADDLE_W - PADDLE_STEP);
    localparam logic [9:0] HS        = 10'(H_ACT_START);
    localparam logic [9:0] HE        = 10'(H_ACT_START + H_ACT);
    localparam logic [9:0] VS        = 10'(V_ACT_START);
    localparam logic [9:0] VE        = 10'(V_ACT_START + V_ACT);

    game_state_t      state, state_n;
    logic [CNT_W-1:0] serve_cnt, serve_cnt_n;
    logic [9:0]       ball_x_n, ball_y_n;
    logic             vx, vx_n;
    logic             vy, vy_n;
    logic [9:0]       paddle_x, paddle_x_n;
    logic             miss_n;
    logic             tick;

    logic [9:0] px, py;
    logic       in_active, in_ball, in_paddle;
    logic [7:0] rgb_n;

    frame_tick u_frame_tick (
        .clk   (clk),
        .reset (reset),
        .hc    (hc),
        .vc    (vc),
        .tick  (tick)
    );

    // Game state register; vx/vy are 1 for right/down and 0 for left/up.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= SERVE;
            serve_cnt <= '0;
            ball_x    <= BALL_X0;
            ball_y    <= BALL_Y0;
            vx        <= 1'b1;
            vy        <= 1'b0;
            paddle_x  <= PADDLE_X0;
            miss      <= 1'b0;
        end else begin
            state     <= state_n;
            serve_cnt <= serve_cnt_n;
            ball_x    <= ball_x_n;
            ball_y    <= ball_y_n;
            vx        <= vx_n;
            vy        <= vy_n;
            paddle_x  <= paddle_x_n;
            miss      <= miss_n;
        end
    end

    // Next-state logic: everything holds except on the frame tick, where the paddle,
    // serve countdown and ball physics advance; bounds are compared before stepping.
    always_comb begin
        state_n     = state;
        serve_cnt_n = serve_cnt;
        ball_x_n    = ball_x;
        ball_y_n    = ball_y;
        vx_n        = vx;
        vy_n        = vy;
        paddle_x_n  = paddle_x;
        miss_n      = 1'b0;

        if (tick) begin
            if (btn_left && !btn_right) begin
                if (paddle_x < PSTEP) paddle_x_n = '0;
                else                  paddle_x_n = paddle_x - PSTEP;
            end else if (btn_right && !btn_left) begin
                if (paddle_x >= P_RCLAMP) paddle_x_n = P_MAX;
                else                      paddle_x_n = paddle_x + PSTEP;
            end

            case (state)
                SERVE: begin
                    ball_x_n = BALL_X0;
                    ball_y_n = BALL_Y0;
                    vx_n     = 1'b1;
                    vy_n     = 1'b0;
                    if (serve_cnt == SERVE_LAST) begin
                        state_n     = PLAY;
                        serve_cnt_n = '0;
                    end else begin
                        serve_cnt_n = serve_cnt + CNT_W'(1);
                    end
                end
                PLAY: begin
                    if (vx) begin
                        if (ball_x + BSTEP >= X_MAX) begin
                            ball_x_n = X_MAX;
                            vx_n     = 1'b0;
                        end else begin
                            ball_x_n = ball_x + BSTEP;
                        end
                    end else begin
                        if (ball_x < BSTEP) begin
                            ball_x_n = '0;
                            vx_n     = 1'b1;
                        end else begin
                            ball_x_n = ball_x - BSTEP;
                        end
                    end

                    if (!vy) begin
                        if (ball_y < BSTEP) begin
                            ball_y_n = '0;
                            vy_n     = 1'b1;
                        end else begin
                            ball_y_n = ball_y - BSTEP;
                        end
                    end else if ((ball_y + BSZ + BSTEP >= PTOP) &&
                                 (ball_x + BSZ > paddle_x) && (ball_x < paddle_x + PW)) begin
                        ball_y_n = Y_HIT;
                        vy_n     = 1'b0;
                    end else if (ball_y + BSTEP >= Y_MAX) begin
                        miss_n      = 1'b1;
                        state_n     = SERVE;
                        serve_cnt_n = '0;
                        ball_x_n    = BALL_X0;
                        ball_y_n    = BALL_Y0;
                        vx_n        = 1'b1;
                        vy_n        = 1'b0;
                    end else begin
                        ball_y_n = ball_y + BSTEP;
                    end
                end
                default: state_n = SERVE;
            endcase
        end
    end

    // Pixel classification for the current counters; ball wins over paddle.
    always_comb begin
        px        = hc - HS;
        py        = vc - VS;
        in_active = (hc >= HS) && (hc < HE) && (vc >= VS) && (vc < VE);
        in_ball   = (px >= ball_x) && (px < ball_x + BSZ) &&
                    (py >= ball_y) && (py < ball_y + BSZ);
        in_paddle = (px >= paddle_x) && (px < paddle_x + PW) &&
                    (py >= PTOP) && (py < PBOT);
        rgb_n     = COL_BG;
        if (!in_active)     rgb_n = 8'h00;
        else if (in_ball)   rgb_n = COL_BALL;
        else if (in_paddle) rgb_n = COL_PADDLE;
    end

    // Registered pixel output, one clock behind hc/vc.
    always_ff @(posedge clk) begin
        if (reset) rgb <= 8'h00;
        else       rgb <= rgb_n;
    end

endmodule

// File: tb/tb_ball_paddle_render.sv
// Testbench for ball_paddle_render: drives hc/vc directly and scoreboards pixels and positions.
module tb_ball_paddle_render;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] hc, vc;
    logic       btn_left, btn_right;
    logic [7:0] rgb_a, rgb_b;
    logic [9:0] bx_a, by_a, bx_b, by_b;
    logic       miss_a, miss_b;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] exp_rgb_q[$];
    int         exp_x_q[$];
    int         exp_y_q[$];

    always #5 clk = ~clk;

    // Default serve delay of 60 frames
    ball_paddle_render dut (
        .clk(clk), .reset(reset), .hc(hc), .vc(vc),
        .btn_left(btn_left), .btn_right(btn_right),
        .rgb(rgb_a), .ball_x(bx_a), .ball_y(by_a), .miss(miss_a)
    );

    // One-frame serve delay so play starts on the first tick
    ball_paddle_render #(.SERVE_FRAMES(1)) dut1 (
        .clk(clk), .reset(reset), .hc(hc), .vc(vc),
        .btn_left(btn_left), .btn_right(btn_right),
        .rgb(rgb_b), .ball_x(bx_b), .ball_y(by_b), .miss(miss_b)
    );

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; hc = 10'd1; vc = 10'd0; btn_left = 1'b0; btn_right = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One frame: origin for two clocks (only the first may tick), then off-origin.
    task automatic do_tick(output logic ma, output logic mb, output logic ma2, output logic mb2);
        @(negedge clk); hc = 10'd0; vc = 10'd0;
        @(posedge clk); #1; ma = miss_a; mb = miss_b;
        @(posedge clk); #1; ma2 = miss_a; mb2 = miss_b;
        @(negedge clk); hc = 10'd1; vc = 10'd0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; hc = 10'd460; vc = 10'd267; btn_left = 1'b0; btn_right = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++; if (rgb_a !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_rgb got %h want 00", rgb_a); end
        tests_run++; if (bx_a !== 10'd316) begin tests_failed++; $display("[TB] FAIL reset_ball_x got %0d want 316", bx_a); end
        tests_run++; if (by_a !== 10'd236) begin tests_failed++; $display("[TB] FAIL reset_ball_y got %0d want 236", by_a); end
        tests_run++; if (miss_a !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_miss got %b want 0", miss_a); end
        tests_run++; if (dut.paddle_x !== 10'd288) begin tests_failed++; $display("[TB] FAIL reset_paddle got %0d want 288", dut.paddle_x); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_render();
        int hv[10][3] = '{
            '{460, 267, 8'hFF}, '{100, 267, 8'h00}, '{444, 491, 8'h1F},
            '{143, 267, 8'h00}, '{467, 274, 8'hFF}, '{468, 267, 8'h00},
            '{432, 487, 8'h1F}, '{496, 487, 8'h00}, '{444, 495, 8'h00},
            '{460, 511, 8'h00}
        };
        logic [7:0] e;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            hc = 10'(hv[i][0]); vc = 10'(hv[i][1]);
            exp_rgb_q.push_back(8'(hv[i][2]));
            @(posedge clk); #1;
            e = exp_rgb_q.pop_front();
            tests_run++;
            if (rgb_a !== e) begin
                tests_failed++;
                $display("[TB] FAIL render_%0d hc=%0d vc=%0d got %h want %h", i, hv[i][0], hv[i][1], rgb_a, e);
            end
        end
    endtask

    task automatic test_serve();
        logic ma, mb, ma2, mb2;
        int ex, ey;
        do_reset();
        for (int t = 1; t <= 61; t++) begin
            exp_x_q.push_back(t <= 60 ? 316 : 318);
            exp_y_q.push_back(t <= 60 ? 236 : 234);
            do_tick(ma, mb, ma2, mb2);
            ex = exp_x_q.pop_front(); ey = exp_y_q.pop_front();
            tests_run++;
            if (bx_a !== 10'(ex) || by_a !== 10'(ey) || ma !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL serve_tick%0d got (%0d,%0d) miss=%b want (%0d,%0d) miss=0", t, bx_a, by_a, ma, ex, ey);
            end
        end
    endtask

    task automatic test_wall_bounce();
        logic ma, mb, ma2, mb2;
        int ex, ey;
        do_reset();
        do_tick(ma, mb, ma2, mb2);
        for (int p = 1; p <= 120; p++) begin
            if (p == 118) begin exp_x_q.push_back(552); exp_y_q.push_back(0); end
            if (p == 119) begin exp_x_q.push_back(554); exp_y_q.push_back(0); end
            if (p == 120) begin exp_x_q.push_back(556); exp_y_q.push_back(2); end
            do_tick(ma, mb, ma2, mb2);
            if (p >= 118) begin
                ex = exp_x_q.pop_front(); ey = exp_y_q.pop_front();
                tests_run++;
                if (bx_b !== 10'(ex) || by_b !== 10'(ey)) begin
                    tests_failed++;
                    $display("[TB] FAIL wall_play%0d got (%0d,%0d) want (%0d,%0d)", p, bx_b, by_b, ex, ey);
                end
            end
        end
    endtask

    task automatic test_paddle();
        logic ma, mb, ma2, mb2;
        do_reset();
        btn_left = 1'b1;
        repeat (80) do_tick(ma, mb, ma2, mb2);
        tests_run++;
        if (dut1.paddle_x !== 10'd0) begin tests_failed++; $display("[TB] FAIL paddle_left_clamp got %0d want 0", dut1.paddle_x); end
        btn_left = 1'b0; btn_right = 1'b1;
        repeat (3) do_tick(ma, mb, ma2, mb2);
        tests_run++;
        if (dut1.paddle_x !== 10'd12) begin tests_failed++; $display("[TB] FAIL paddle_right_step got %0d want 12", dut1.paddle_x); end
        btn_left = 1'b1;
        repeat (5) do_tick(ma, mb, ma2, mb2);
        tests_run++;
        if (dut1.paddle_x !== 10'd12) begin tests_failed++; $display("[TB] FAIL paddle_both_hold got %0d want 12", dut1.paddle_x); end
        btn_left = 1'b0;
        repeat (150) do_tick(ma, mb, ma2, mb2);
        tests_run++;
        if (dut.paddle_x !== 10'd576) begin tests_failed++; $display("[TB] FAIL paddle_right_clamp got %0d want 576", dut.paddle_x); end
        btn_right = 1'b0;
    endtask

    task automatic test_miss();
        logic ma, mb, ma2, mb2;
        int miss_tick = -1;
        int pulses = 0;
        int long_pulses = 0;
        do_reset();
        btn_left = 1'b1;
        for (int n = 1; n <= 358; n++) begin
            if (n >= 356) begin
                exp_x_q.push_back(n == 358 ? 318 : 316);
                exp_y_q.push_back(n == 358 ? 234 : 236);
            end
            do_tick(ma, mb, ma2, mb2);
            if (mb === 1'b1) begin pulses++; if (miss_tick < 0) miss_tick = n; end
            if (mb2 !== 1'b0) long_pulses++;
            if (n >= 356) begin
                int ex, ey;
                ex = exp_x_q.pop_front(); ey = exp_y_q.pop_front();
                tests_run++;
                if (bx_b !== 10'(ex) || by_b !== 10'(ey)) begin
                    tests_failed++;
                    $display("[TB] FAIL miss_ball_tick%0d got (%0d,%0d) want (%0d,%0d)", n, bx_b, by_b, ex, ey);
                end
            end
        end
        btn_left = 1'b0;
        tests_run++;
        if (miss_tick != 356) begin tests_failed++; $display("[TB] FAIL miss_tick got %0d want 356", miss_tick); end
        tests_run++;
        if (pulses != 1) begin tests_failed++; $display("[TB] FAIL miss_pulses got %0d want 1", pulses); end
        tests_run++;
        if (long_pulses != 0) begin tests_failed++; $display("[TB] FAIL miss_width got %0d extra-clock highs want 0", long_pulses); end
    endtask

    task automatic test_paddle_hit();
        logic ma, mb, ma2, mb2;
        int pulses = 0;
        int ex, ey;
        do_reset();
        btn_left = 1'b1;
        for (int n = 1; n <= 345; n++) begin
            if (n == 7) btn_left = 1'b0;
            if (n == 344) begin exp_x_q.push_back(262); exp_y_q.push_back(448); end
            if (n == 345) begin exp_x_q.push_back(260); exp_y_q.push_back(446); end
            do_tick(ma, mb, ma2, mb2);
            if (mb !== 1'b0 || mb2 !== 1'b0) pulses++;
            if (n == 6) begin
                tests_run++;
                if (dut1.paddle_x !== 10'd264) begin tests_failed++; $display("[TB] FAIL hit_paddle_pos got %0d want 264", dut1.paddle_x); end
            end
            if (n >= 344) begin
                ex = exp_x_q.pop_front(); ey = exp_y_q.pop_front();
                tests_run++;
                if (bx_b !== 10'(ex) || by_b !== 10'(ey)) begin
                    tests_failed++;
                    $display("[TB] FAIL hit_ball_tick%0d got (%0d,%0d) want (%0d,%0d)", n, bx_b, by_b, ex, ey);
                end
            end
        end
        tests_run++;
        if (pulses != 0) begin tests_failed++; $display("[TB] FAIL hit_no_miss got %0d miss samples want 0", pulses); end
    endtask

    initial begin
        reset = 1'b1; hc = 10'd1; vc = 10'd0; btn_left = 1'b0; btn_right = 1'b0;
        test_reset();
        test_render();
        test_serve();
        test_wall_bounce();
        test_paddle();
        test_miss();
        test_paddle_hit();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
